input_cond: RTL and testbench

- Board-input conditioner: the input-direction counterpart of the display/LED output path.
- Synchronizes, debounces and edge-detects raw buttons and switches.
- Presents clean levels plus sticky event bits (with interrupt request) to the computer's input ports (PORTI/PORTJ, irqs).
- Replaces crude sampling of pads on a slow divided clock; runs entirely in one clock domain.

---
 rtl/input_cond.sv | 82 ++++++++
 tb/tb_input_cond.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/input_cond.sv
// input_cond: synchronizes, debounces and edge-detects board inputs, with sticky events and irq.
// Define INPUT_COND_FALL_EVT_EN to make releases (fall) set evt as well as presses.
module input_cond #(
  parameter int WIDTH      = 8,
  parameter int TICK_DIV   = 1000,
  parameter int STABLE_CNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] evt_clr,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] evt,
  output logic             irq,
  output logic             tick
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [3:0] CNT_MAX = 4'(STABLE_CNT - 1);
  logic [PW-1:0] pre_q, pre_d;
  logic tick_q, tick_d, irq_q, irq_d;
  logic [WIDTH-1:0] sync_q, s_q, dout_q, dout_d, rise_q, rise_d, fall_q, fall_d, evt_q, evt_d;
  logic [3:0] cnt_q [WIDTH];
  logic [3:0] cnt_d [WIDTH];
  always_comb begin
    pre_d  = pre_q == PRE_MAX ? '0 : pre_q + 1'b1;
    tick_d = pre_q == PRE_MAX;
    dout_d = dout_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick_q) begin
        if (s_q[i] == dout_q[i]) cnt_d[i] = '0;
        else if (cnt_q[i] == CNT_MAX) begin
          dout_d[i] = s_q[i];
          cnt_d[i]  = '0;
        end else cnt_d[i] = cnt_q[i] + 4'd1;
      end
    end
    rise_d = dout_d & ~dout_q;
    fall_d = ~dout_d & dout_q;
    // set sources are OR'd after the clear so a same-cycle event is never lost
`ifdef INPUT_COND_FALL_EVT_EN
    evt_d = (evt_q & ~evt_clr) | rise_q | fall_q;
`else
    evt_d = (evt_q & ~evt_clr) | rise_q;
`endif
    irq_d = |evt_d;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
      sync_q <= '0;
      s_q    <= '0;
      dout_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
      evt_q  <= '0;
      irq_q  <= 1'b0;
      cnt_q  <= '{default: '0};
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
      sync_q <= din;
      s_q    <= sync_q;
      dout_q <= dout_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      evt_q  <= evt_d;
      irq_q  <= irq_d;
      cnt_q  <= cnt_d;
    end
  end
  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign evt  = evt_q;
  assign irq  = irq_q;
  assign tick = tick_q;
endmodule

// File: tb/tb_input_cond.sv
// tb_input_cond: vector table plus per-cycle scoreboard against a behavioural model of input_cond.
module tb_input_cond;
  localparam int W = 4, TD = 4, SC = 3;
  logic clk = 0, rst = 1;
  logic [W-1:0] din = '0, clr = '0;
  logic [W-1:0] dout, rise, fall, evt;
  logic irq, tick;
  int checks = 0, failures = 0;
  input_cond #(.WIDTH(W), .TICK_DIV(TD), .STABLE_CNT(SC)) dut (
    .clk(clk), .reset(rst), .din(din), .evt_clr(clr), .dout(dout), .rise(rise),
    .fall(fall), .evt(evt), .irq(irq), .tick(tick));
  always #5 clk = ~clk;
  typedef struct packed {
    logic [W-1:0] dout, rise, fall, evt;
    logic irq, tick;
  } obs_t;
  obs_t sb_q[$];
  logic [W-1:0] m_s1 = '0, m_s = '0, m_dout = '0, m_rise = '0, m_fall = '0, m_evt = '0;
  logic m_irq = 0, m_tick = 0;
  int m_pre = 0;
  int m_cnt [W];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic model_step();
    logic [W-1:0] nd;
    if (rst) begin
      m_s1 = '0; m_s = '0; m_dout = '0; m_rise = '0; m_fall = '0; m_evt = '0;
      m_irq = 0; m_tick = 0; m_pre = 0;
      for (int i = 0; i < W; i++) m_cnt[i] = 0;
    end else begin
      nd = m_dout;
      if (m_tick)
        for (int i = 0; i < W; i++) begin
          if (m_s[i] == m_dout[i]) m_cnt[i] = 0;
          else if (m_cnt[i] + 1 >= SC) begin nd[i] = m_s[i]; m_cnt[i] = 0; end
          else m_cnt[i]++;
        end
`ifdef INPUT_COND_FALL_EVT_EN
      m_evt = (m_evt & ~clr) | m_rise | m_fall;
`else
      m_evt = (m_evt & ~clr) | m_rise;
`endif
      m_irq = |m_evt;
      m_rise = nd & ~m_dout;
      m_fall = ~nd & m_dout;
      m_dout = nd;
      m_tick = (m_pre == TD - 1);
      m_pre = (m_pre == TD - 1) ? 0 : m_pre + 1;
      m_s = m_s1;
      m_s1 = din;
    end
    sb_q.push_back('{m_dout, m_rise, m_fall, m_evt, m_irq, m_tick});
  endtask
  task automatic cyc();
    obs_t e;
    model_step();
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("scoreboard", 32'({dout, rise, fall, evt, irq, tick}), 32'(e));
  endtask
  // which: 0 = tick, 1 = rise[0], 2 = dout[0]
  task automatic wait_for(input int which, input string name, output int k);
    bit hit = 0;
    for (k = 1; k <= 60; k++) begin
      cyc();
      hit = which == 0 ? tick : which == 1 ? rise[0] : dout[0];
      if (hit) break;
    end
    if (!hit) begin
      failures++;
      $display("FAIL %s: timeout waiting 60 cycles", name);
    end
  endtask
  typedef struct {
    logic [W-1:0] din, clr;
    int n;
    logic [W-1:0] dout, evt;
    logic irq;
    int nrise, nfall;
  } vec_t;
  vec_t tbl [6];
  initial begin
    int k, nr, nf;
    logic [W-1:0] e5;
`ifdef INPUT_COND_FALL_EVT_EN
    e5 = 4'h4;
`else
    e5 = 4'h0;
`endif
    tbl[0] = '{4'h0, 4'hF, 24, 4'h0, 4'h0, 0, 0, 1};
    tbl[1] = '{4'h1, 4'h0, 24, 4'h1, 4'h1, 1, 1, 0};
    tbl[2] = '{4'h1, 4'hF, 2, 4'h1, 4'h0, 0, 0, 0};
    tbl[3] = '{4'h5, 4'h0, 24, 4'h5, 4'h4, 1, 1, 0};
    tbl[4] = '{4'h5, 4'hF, 2, 4'h5, 4'h0, 0, 0, 0};
    tbl[5] = '{4'h1, 4'h0, 24, 4'h1, e5, |e5, 0, 1};
    for (int i = 0; i < W; i++) m_cnt[i] = 0;
    rst = 1; din = 4'hF;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("reset_outputs", 32'({dout, rise, fall, evt, irq, tick}), 32'h0);
    end
    rst = 0;
    wait_for(0, "first_tick", k);
    chk("first_tick_delay", k, 4);
    wait_for(2, "powerup_flip", k);
    chk("powerup_flip_delay", k, 9);
    chk("powerup_dout", dout, 4'hF);
    chk("powerup_rise", rise, 4'hF);
    cyc();
    chk("powerup_rise_end", rise, 4'h0);
    chk("powerup_evt", evt, 4'hF);
    chk("powerup_irq", irq, 1);
    for (int v = 0; v < 6; v++) begin
      din = tbl[v].din; clr = tbl[v].clr; nr = 0; nf = 0;
      for (int c = 0; c < tbl[v].n; c++) begin
        cyc();
        nr += int'(|rise);
        nf += int'(|fall);
      end
      chk($sformatf("vec%0d_dout", v), dout, tbl[v].dout);
      chk($sformatf("vec%0d_evt", v), evt, tbl[v].evt);
      chk($sformatf("vec%0d_irq", v), irq, tbl[v].irq);
      chk($sformatf("vec%0d_rises", v), nr, tbl[v].nrise);
      chk($sformatf("vec%0d_falls", v), nf, tbl[v].nfall);
    end
    clr = 4'hF; cyc(); clr = 0;
    wait_for(0, "glitch_align", k);
    din = 4'h3;
    for (int c = 0; c < 8; c++) cyc();
    din = 4'h1; nr = 0; nf = 0;
    for (int c = 0; c < 24; c++) begin
      cyc();
      nr += int'(|rise);
      nf += int'(|fall);
    end
    chk("glitch_dout", dout, 4'h1);
    chk("glitch_edges", nr + nf, 0);
    chk("glitch_evt", evt, 4'h0);
    din = 4'h0;
    for (int c = 0; c < 24; c++) cyc();
    clr = 4'hF; cyc(); clr = 0;
    din = 4'h1;
    wait_for(1, "rise0_a", k);
    cyc(); cyc();
    chk("evt_after_rise", evt, 4'h1);
    din = 4'h0;
    for (int c = 0; c < 24; c++) cyc();
    chk("evt_kept_dout", {evt, dout}, 8'h10);
    din = 4'h1;
    wait_for(1, "rise0_b", k);
    clr = 4'h1; cyc(); clr = 0;
    chk("set_beats_clear", evt, 4'h1);
    cyc();
    chk("evt_still_set", {evt, 3'b0, irq}, 8'h11);
    clr = 4'h1; cyc(); clr = 0;
    chk("clear_evt_irq", {evt, 3'b0, irq}, 8'h00);
    din = 4'h0;
    for (int c = 0; c < 24; c++) cyc();
    wait_for(0, "midcount_align", k);
    din = 4'h1;
    for (int c = 0; c < 9; c++) cyc();
    chk("midcount_no_flip", dout, 4'h0);
    rst = 1; cyc(); rst = 0;
    chk("midcount_reset_outs", 32'({dout, rise, fall, evt, irq, tick}), 32'h0);
    wait_for(2, "midcount_reflip", k);
    chk("midcount_full_restart", k, 13);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
